sram_access_sequencer: RTL and testbench
========================================

Name: sram_access_sequencer

Overview:
- Upstream stage for the SRAM controller. Accepts single read/write requests from an on-chip master over a valid/ready handshake.
- Sequences the controller's read_en/wr_en, address, write data and byte enables for a fixed number of access cycles.
- Captures read data and returns it over a valid/ready response channel.
- Serialises all SRAM traffic: one access in flight, no pipelining.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.
- BE_W, 2, byte-enable width (DATA_W/8).
- WAIT_CYC, 2, cycles read_en/wr_en stay asserted per access; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be_n  in  BE_W  active-low byte enables, bit1 = upper byte
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  master accepts read data
- rsp_rdata  out  DATA_W  captured read data
- wr_done  out  1  one-cycle pulse when a write access finishes
- ctl_read_en  out  1  to controller read_en
- ctl_wr_en  out  1  to controller wr_en
- ctl_address  out  ADDR_W  to controller address
- ctl_wr_data  out  DATA_W  to controller wr_data
- ctl_byte_en_n  out  BE_W  to controller byteEnable_n
- ctl_read_data  in  DATA_W  from controller read_data

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All state registers on posedge clk / negedge rst_n.
- Reset values: state IDLE, counter 0, ctl_read_en 0, ctl_wr_en 0, ctl_address 0, ctl_wr_data 0, ctl_byte_en_n all 1s, rsp_valid 0, rsp_rdata 0, wr_done 0. req_ready is 0 while rst_n is low.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1 (combinational, state==IDLE).
  - On req_valid: register addr, wdata, be_n and we into the ctl_* outputs. Assert ctl_read_en = ~req_we and ctl_wr_en = req_we. Load counter = WAIT_CYC-1. Go to ACCESS.
- ACCESS:
  - req_ready = 0. Enables, address, data and byte enables are held stable.
  - Counter decrements each cycle.
  - When counter==0 (last access cycle):
    - Read: capture ctl_read_data into rsp_rdata, drop enables, set rsp_valid, go to RESP.
    - Write: drop enables, pulse wr_done for exactly one cycle, go to IDLE.
- RESP:
  - rsp_valid and rsp_rdata held until rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
  - rsp_ready asserted before rsp_valid has no effect.
- Idle bus conditions:
  - Outside ACCESS, both enables are 0 and ctl_byte_en_n = all 1s.
  - ctl_address and ctl_wr_data keep their last values.
- Latency:
  - Handshake at cycle T.
  - Enables asserted in cycles T+1 .. T+WAIT_CYC.
  - Read: rsp_valid from cycle T+WAIT_CYC+1.
  - Write: wr_done high in cycle T+WAIT_CYC+1, and req_ready is 1 again in that same cycle.
- Back-to-back:
  - Minimum request spacing is WAIT_CYC+1 cycles for writes, WAIT_CYC+2 for reads when rsp_ready is held high.
  - The IDLE cycle between accesses guarantees enables deassert between accesses (dq turnaround).
- ctl_read_en and ctl_wr_en are never both 1.
- req_* inputs are ignored when req_ready = 0 and may change freely then.
- Reset mid-operation (any state): enables drop immediately (async), any pending response is discarded, state returns to IDLE, no wr_done pulse.
- Counter width is 4 bits. WAIT_CYC = 1 means a single ACCESS cycle.

Decomposition:
- Shared package sram_pkg:
  - Constants SRAM_ADDR_W = 18, SRAM_DATA_W = 16, SRAM_BE_W = 2.
  - Enum sram_seq_state_t {IDLE, ACCESS, RESP}.
  - Packed struct sram_req_t {we, addr, wdata, be_n}.
- No sub-module: the FSM, counter and output registers stay flat in one module.

Test Plan:
- Reset: hold rst_n = 0 with req_valid = 1 -> req_ready = 0, both enables 0, ctl_byte_en_n = 2'b11, rsp_valid = 0.
- Write, WAIT_CYC = 2: req_we = 1, addr = 18'h3_0010, wdata = 16'hBEEF, be_n = 2'b00 at T -> ctl_wr_en = 1 with those values in T+1 and T+2; wr_done = 1 only in T+3; ctl_read_en = 0 throughout.
- Read: req_we = 0, addr = 18'h0_0055, model returns 16'hA5C3 -> ctl_read_en = 1 in T+1..T+2; rsp_valid from T+3 with rsp_rdata = 16'hA5C3.
- Response backpressure: rsp_ready = 0 for 5 cycles after read -> rsp_valid/rsp_rdata stable, req_ready = 0; rsp_ready = 1 -> rsp_valid = 0 and req_ready = 1 next cycle.
- Byte write: be_n = 2'b10 (lower byte only), back-to-back with a read to the same address, req_valid held high -> one cycle with both enables 0 between accesses; read returns the merged word.
- Mid-access reset: assert rst_n = 0 in the second ACCESS cycle of a write -> enables 0 immediately, no wr_done; after release, req_ready = 1 and a new read completes normally.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM access path.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_BE_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } sram_seq_state_t;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_BE_W-1:0]   be_n;
  } sram_req_t;

endpackage

// File: rtl/sram_access_sequencer.sv
// Single-outstanding SRAM access sequencer: request in, timed enables out,
// read data back over a valid/ready response channel.
module sram_access_sequencer
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int BE_W     = SRAM_BE_W,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be_n,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              ctl_read_en,
  output logic              ctl_wr_en,
  output logic [ADDR_W-1:0] ctl_address,
  output logic [DATA_W-1:0] ctl_wr_data,
  output logic [BE_W-1:0]   ctl_byte_en_n,
  input  logic [DATA_W-1:0] ctl_read_data
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  sram_seq_state_t state, state_nxt;
  logic [3:0]      cnt;
  logic            accept;
  logic            last_cyc;
  logic            rsp_take;

  // Ready only in IDLE and never while reset is held.
  assign req_ready = (state == IDLE) && rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_cyc  = 1'b0;
    rsp_take  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = req_valid;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        last_cyc = (cnt == 4'd0);
        if (last_cyc) state_nxt = ctl_read_en ? RESP : IDLE;
      end
      RESP: begin
        rsp_take = rsp_ready;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Controller-side bus: launch on accept, hold through ACCESS, park after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      ctl_read_en   <= 1'b0;
      ctl_wr_en     <= 1'b0;
      ctl_address   <= '0;
      ctl_wr_data   <= '0;
      ctl_byte_en_n <= '1;
    end else if (accept) begin
      cnt           <= CNT_LOAD;
      ctl_read_en   <= ~req_we;
      ctl_wr_en     <= req_we;
      ctl_address   <= req_addr;
      ctl_wr_data   <= req_wdata;
      ctl_byte_en_n <= req_be_n;
    end else if (last_cyc) begin
      ctl_read_en   <= 1'b0;
      ctl_wr_en     <= 1'b0;
      ctl_byte_en_n <= '1;
    end else if (state == ACCESS) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response side: capture read data on the last access cycle, pulse wr_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_done   <= 1'b0;
    end else begin
      wr_done <= last_cyc && ctl_wr_en;
      if (last_cyc && ctl_read_en) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= ctl_read_data;
      end else if (rsp_take) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with a small byte-maskable SRAM model.
module tb_sram_access_sequencer;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [17:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be_n = 2'b11;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        wr_done;
  logic        ctl_read_en, ctl_wr_en;
  logic [17:0] ctl_address;
  logic [15:0] ctl_wr_data;
  logic [1:0]  ctl_byte_en_n;
  logic [15:0] ctl_read_data;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  sram_access_sequencer #(.WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be_n(req_be_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done),
    .ctl_read_en(ctl_read_en), .ctl_wr_en(ctl_wr_en),
    .ctl_address(ctl_address), .ctl_wr_data(ctl_wr_data),
    .ctl_byte_en_n(ctl_byte_en_n), .ctl_read_data(ctl_read_data)
  );

  always #5 clk = ~clk;

  // SRAM model: async read, byte-masked write on clock edge.
  assign ctl_read_data = mem[ctl_address[7:0]];
  always @(posedge clk) begin
    if (ctl_wr_en) begin
      if (!ctl_byte_en_n[0]) mem[ctl_address[7:0]][7:0]  <= ctl_wr_data[7:0];
      if (!ctl_byte_en_n[1]) mem[ctl_address[7:0]][15:8] <= ctl_wr_data[15:8];
    end
  end

  // Never both enables.
  always @(negedge clk) begin
    if (ctl_read_en && ctl_wr_en) begin
      errors++;
      $display("FAIL excl_en both enables high at %0t", $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({req_ready, ctl_read_en, ctl_wr_en, ctl_byte_en_n, rsp_valid, wr_done} !== 7'b0001100) begin
        errors++;
        $display("FAIL reset rdy/ren/wen/be_n/rv/wd got %b want 0001100",
                 {req_ready, ctl_read_en, ctl_wr_en, ctl_byte_en_n, rsp_valid, wr_done});
      end
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_rel req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    // cycle T
    req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h3_0010; req_wdata = 16'hBEEF; req_be_n = 2'b00;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_T req_ready got %b want 1", req_ready); end
    step(); req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_be_n = 2'b11;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if ({ctl_wr_en, ctl_read_en, ctl_address, ctl_wr_data, ctl_byte_en_n, wr_done, req_ready}
          !== {1'b1, 1'b0, 18'h3_0010, 16'hBEEF, 2'b00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL wr_T+%0d wen=%b ren=%b addr=%h data=%h be=%b wd=%b rdy=%b want 1 0 30010 beef 00 0 0",
                 i, ctl_wr_en, ctl_read_en, ctl_address, ctl_wr_data, ctl_byte_en_n, wr_done, req_ready);
      end
      step();
    end
    // T+3
    checks++;
    if ({wr_done, ctl_wr_en, ctl_read_en, ctl_byte_en_n, req_ready, ctl_address} !== {5'b10011, 1'b1, 18'h3_0010}) begin
      errors++;
      $display("FAIL wr_T+3 wd=%b wen=%b ren=%b be=%b rdy=%b addr=%h want 1 0 0 11 1 30010",
               wr_done, ctl_wr_en, ctl_read_en, ctl_byte_en_n, req_ready, ctl_address);
    end
    step();
    checks++;
    if (wr_done !== 1'b0) begin errors++; $display("FAIL wr_T+4 wr_done got %b want 0", wr_done); end
    checks++;
    if (mem[8'h10] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem got %h want beef", mem[8'h10]); end
  endtask

  task automatic test_read_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h0_0055;
    step(); req_valid = 1'b0; req_we = 1'b1; req_addr = 18'h3_FFFF;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if ({ctl_read_en, ctl_wr_en, ctl_address, rsp_valid} !== {1'b1, 1'b0, 18'h0_0055, 1'b0}) begin
        errors++;
        $display("FAIL rd_T+%0d ren=%b wen=%b addr=%h rv=%b want 1 0 00055 0",
                 i, ctl_read_en, ctl_wr_en, ctl_address, rsp_valid);
      end
      step();
    end
    // T+3 onward: response held under backpressure
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_rdata, req_ready, ctl_read_en, wr_done} !== {1'b1, 16'hA5C3, 3'b000}) begin
        errors++;
        $display("FAIL rd_hold%0d rv=%b data=%h rdy=%b ren=%b wd=%b want 1 a5c3 0 0 0",
                 i, rsp_valid, rsp_rdata, req_ready, ctl_read_en, wr_done);
      end
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_release rv=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    want = 16'h1256;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h0_0020; req_wdata = 16'hAB56; req_be_n = 2'b10;
    step(); // T+1
    req_we = 1'b0; req_wdata = 16'h0000; req_be_n = 2'b00;
    checks++;
    if ({ctl_wr_en, ctl_byte_en_n} !== 3'b110) begin
      errors++; $display("FAIL b2b_wr wen=%b be=%b want 1 10", ctl_wr_en, ctl_byte_en_n);
    end
    step(); // T+2
    step(); // T+3: idle gap, read accepted here
    checks++;
    if ({ctl_read_en, ctl_wr_en, ctl_byte_en_n, wr_done, req_ready} !== 6'b001111) begin
      errors++;
      $display("FAIL b2b_gap ren=%b wen=%b be=%b wd=%b rdy=%b want 0 0 11 1 1",
               ctl_read_en, ctl_wr_en, ctl_byte_en_n, wr_done, req_ready);
    end
    step(); // T+4
    req_valid = 1'b0;
    checks++;
    if ({ctl_read_en, ctl_wr_en, ctl_address} !== {2'b10, 18'h0_0020}) begin
      errors++; $display("FAIL b2b_rd ren=%b wen=%b addr=%h want 1 0 00020", ctl_read_en, ctl_wr_en, ctl_address);
    end
    step(); // T+5
    step(); // T+6
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, want}) begin
      errors++; $display("FAIL b2b_rsp rv=%b data=%h want 1 %h", rsp_valid, rsp_rdata, want);
    end
    step(); // T+7
    checks++;
    if ({rsp_valid, req_ready, ctl_read_en} !== 3'b010) begin
      errors++; $display("FAIL b2b_end rv=%b rdy=%b ren=%b want 0 1 0", rsp_valid, req_ready, ctl_read_en);
    end
  endtask

  task automatic test_mid_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h0_0030; req_wdata = 16'h7777; req_be_n = 2'b00;
    step(); req_valid = 1'b0; // T+1
    step();                   // T+2: second access cycle
    checks++;
    if (ctl_wr_en !== 1'b1) begin errors++; $display("FAIL mrst_pre wen got %b want 1", ctl_wr_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ctl_wr_en, ctl_read_en, ctl_byte_en_n, wr_done, req_ready} !== 6'b001100) begin
      errors++;
      $display("FAIL mrst_async wen=%b ren=%b be=%b wd=%b rdy=%b want 0 0 11 0 0",
               ctl_wr_en, ctl_read_en, ctl_byte_en_n, wr_done, req_ready);
    end
    step();
    checks++;
    if (wr_done !== 1'b0) begin errors++; $display("FAIL mrst_wd wr_done got %b want 0", wr_done); end
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mrst_rdy req_ready got %b want 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h0_0055;
    step(); req_valid = 1'b0;
    checks++;
    if (ctl_read_en !== 1'b1) begin errors++; $display("FAIL mrst_rd ren got %b want 1", ctl_read_en); end
    step();
    step();
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 16'hA5C3}) begin
      errors++; $display("FAIL mrst_rsp rv=%b data=%h want 1 a5c3", rsp_valid, rsp_rdata);
    end
    step();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL mrst_end rv=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h55] = 16'hA5C3;
    mem[8'h20] = 16'h1234;
    test_reset();
    test_write();
    test_read_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

endmodule
